popcorn_dp: RTL and testbench
=============================

# popcorn_dp

Parametrised datapath for the next-generation Popcorn accumulator CPU. It holds the accumulator, a register file of NREG general registers, PC, SP, operand latches, flags and the I/O port, plus the ALU and bus muxes. It is driven cycle by cycle by the external sequencer's control strobes. Relative to the fixed 8-bit datapath, it adds configurable width and depth, carry-chained ALU ops, and SP overflow/underflow detection. All operand and opcode latches are synchronous enables on sys_clk rather than separate clocks.

## Interface
- DW, 8, data width; DW >= 8
- AW, 12, address width; DW < AW <= 2*DW-4
- NREG, 4, general registers; power of 2, >= 2
- RSW, log2(NREG), register select width
- sys_clk  in  1  clock
- sys_rst  in  1  reset; asynchronous, active-low
- w_acc, w_reg, w_flag, w_opl, w_oplo, w_ophi  in  1 each  write enables, active-low
- reg_sel  in  RSW  register file read/write index
- alu_func  in  4  ALU operation
- bbus_mux  in  3  B-bus source
- flag_mux  in  1  1 = flags from ALU result, 0 = flags loaded from c_bus
- pc_op, sp_op, addx_mux  in  2 each  PC / SP / address-bus control
- data_bus_wr  in  1  1 = data_out tri-stated (data_oe=0)
- data_in  in  DW  external data bus read
- data_out  out  DW  c_bus; data_oe  out  1  = ~data_bus_wr
- addx_bus  out  AW  external address
- port_in  in  DW  pad input; port_out  out  DW  = reg_p; port_oe  out  1
- c_bus, b_bus  out  DW  ALU result / B operand (debug)
- reg_acc, reg_p, reg_opl  out  DW; reg_flag  out  4  {carry,pos,zero,serr}

## Operation
- Reset values:
  - acc, all reg[i], reg_p, opl, oplo, ophi, PC and flags = 0.
  - SP = all-ones.
  - port_oe = 1 unless bbus_mux = 4.
- d_bus is {ophi[AW-DW-1:0], oplo}.
- On each rising edge:
  - !w_opl/!w_oplo/!w_ophi capture data_in; ophi keeps the low AW-DW bits.
  - !w_acc loads acc with c_bus.
  - !w_reg loads reg[reg_sel] with c_bus.
- B mux:
  - 1 = reg[reg_sel]
  - 2 = PC[DW-1:0]
  - 3 = {flags, zero-fill, PC[AW-1:DW]}
  - 4 = port_in
  - 5 = reg_opl
  - others = d_bus[DW-1:0]
- ALU, with a = acc, b = b_bus, all DW bits, cout as listed:
  - 0 add, cout = carry-out
  - 1 sub, cout = borrow
  - 2 and, 3 or, 4 xor, 5 not-a; cout = 0
  - 6 shr, cout = a[0]
  - 7 shl, cout = a[DW-1]
  - 8 pass b, cout = 0
  - 9 adc: a+b+carry
  - A sbc: a-b-carry, cout = borrow
  - B rcr: {carry, a[DW-1:1]}, cout = a[0]
  - C rcl: {a[DW-2:0], carry}, cout = a[DW-1]
  - others pass a, cout = 0
- Flags on !w_flag:
  - flag_mux=1: zero = (c_bus==0), pos = ~c_bus[DW-1], carry = cout; serr unchanged.
  - flag_mux=0: {carry,pos,zero,serr} = c_bus[DW-1:DW-4].
- pc_op: 0 hold, 1 increment (all-ones wraps to 0), 2 load d_bus, 3 hold.
- sp_op: 0 hold, 1 push (decrement), 2 pop (increment), 3 hold.
  - Push at SP=0 and pop at SP=all-ones leave SP unchanged and set sticky serr.
  - Only reset or a flag_mux=0 load clears serr.
- addx_mux: 0 = d_bus, 1 = PC, 2 = SP, 3 = SP+1 (pop read address, AW-bit wrap).
- port_oe = 0 when bbus_mux = 4, else 1.

## Timing
- Combinational paths: b_bus, c_bus, cout, addx_bus, data_out/oe, port_oe.
- Registered state updates on the edge following its strobe; a value written at edge N is visible on b_bus/addx_bus after edge N.
- A read and a write of the same reg[reg_sel] in one cycle: the read returns the old value, and the new value lands at the edge.
- Simultaneous strobes are independent; all may fire in one cycle.
- serr set by an SP fault beats a flag_mux=0 load in the same cycle; the other three flags still load.
- Asserting sys_rst mid-cycle forces reset values immediately. Deassertion is synchronised externally; first active edge is the next rising sys_clk.

## Test plan
- Reset with default params -> SP=0xFFF, PC=0x000, flags=0, addx_bus=0x000 (addx_mux=0), port_oe=1.
- acc=0xFF, b=0x01, alu=0 with !w_flag (flag_mux=1) -> c_bus=0x00, carry=1, zero=1. Then acc=0x10, b=0x20, alu=9 -> c_bus=0x31.
- Write 0xA5 to reg[3] via alu=8, bbus_mux=5, opl=0xA5 -> after edge, reg_sel=3, bbus_mux=1 gives b_bus=0xA5; reg[0..2] stay 0.
- oplo=0x34, ophi=0x0F, pc_op=2 -> PC=0xF34. Then pc_op=1 repeated 204 times -> PC=0x000.
- SP forced to 0 by 4095 pushes, then push -> SP stays 0, serr=1. A simultaneous flag_mux=0 load of c_bus=0xE0 -> carry/pos/zero=1/1/1, serr stays 1.
- carry=1, acc=0x80, alu=B -> c_bus=0xC0, cout=0. bbus_mux=4 -> port_oe=0, b_bus=port_in.

Source files
------------

// File: rtl/popcorn_dp.sv
// popcorn_dp: accumulator-CPU datapath with register file, PC, SP, operand
// latches, flags and ALU, driven cycle by cycle by external control strobes.
module popcorn_dp #(
  parameter int DW   = 8,
  parameter int AW   = 12,
  parameter int NREG = 4,
  parameter int RSW  = $clog2(NREG)
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           w_acc,
  input  logic           w_reg,
  input  logic           w_flag,
  input  logic           w_opl,
  input  logic           w_oplo,
  input  logic           w_ophi,
  input  logic [RSW-1:0] reg_sel,
  input  logic [3:0]     alu_func,
  input  logic [2:0]     bbus_mux,
  input  logic           flag_mux,
  input  logic [1:0]     pc_op,
  input  logic [1:0]     sp_op,
  input  logic [1:0]     addx_mux,
  input  logic           data_bus_wr,
  input  logic [DW-1:0]  data_in,
  output logic [DW-1:0]  data_out,
  output logic           data_oe,
  output logic [AW-1:0]  addx_bus,
  input  logic [DW-1:0]  port_in,
  output logic [DW-1:0]  port_out,
  output logic           port_oe,
  output logic [DW-1:0]  c_bus,
  output logic [DW-1:0]  b_bus,
  output logic [DW-1:0]  reg_acc,
  output logic [DW-1:0]  reg_p,
  output logic [DW-1:0]  reg_opl,
  output logic [3:0]     reg_flag
);

  localparam int HW = AW - DW;  // width of the high operand latch

  typedef enum logic [1:0] {PC_HOLD = 2'd0, PC_INC = 2'd1, PC_LOAD = 2'd2, PC_HOLD3 = 2'd3} pc_op_e;
  typedef enum logic [1:0] {SP_HOLD = 2'd0, SP_PUSH = 2'd1, SP_POP = 2'd2, SP_HOLD3 = 2'd3} sp_op_e;

  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] reg_p_q, reg_p_d;
  logic [DW-1:0] opl_q, opl_d;
  logic [DW-1:0] oplo_q, oplo_d;
  logic [HW-1:0] ophi_q, ophi_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] sp_q, sp_d;
  logic          carry_q, carry_d, pos_q, pos_d, zero_q, zero_d, serr_q, serr_d;

  logic [AW-1:0] d_bus;
  logic [DW:0]   sum;
  logic          cout;
  logic          sp_fault;

  assign d_bus    = {ophi_q, oplo_q};
  assign reg_acc  = acc_q;
  assign reg_p    = reg_p_q;
  assign reg_opl  = opl_q;
  assign reg_flag = {carry_q, pos_q, zero_q, serr_q};
  assign port_out = reg_p_q;
  assign port_oe  = (bbus_mux != 3'd4);
  assign data_out = c_bus;
  assign data_oe  = ~data_bus_wr;

  // B-bus source select
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    b_bus = d_bus[DW-1:0];
    case (bbus_mux)
      3'd1: b_bus = regs_q[reg_sel];
      3'd2: b_bus = pc_q[DW-1:0];
      3'd3: begin
        b_bus = '0;
        b_bus[DW-1:DW-4] = {carry_q, pos_q, zero_q, serr_q};
        b_bus[HW-1:0]    = pc_q[AW-1:DW];
      end
      3'd4: b_bus = port_in;
      3'd5: b_bus = opl_q;
      default: b_bus = d_bus[DW-1:0];
    endcase
  end

  // ALU: a = acc, b = b_bus; wide sum carries carry-out / borrow in its top bit
  always_comb begin
    sum   = '0;
    c_bus = acc_q;
    cout  = 1'b0;
    case (alu_func)
      4'h0: begin sum = {1'b0, acc_q} + {1'b0, b_bus}; c_bus = sum[DW-1:0]; cout = sum[DW]; end
      4'h1: begin sum = {1'b0, acc_q} - {1'b0, b_bus}; c_bus = sum[DW-1:0]; cout = sum[DW]; end
      4'h2: c_bus = acc_q & b_bus;
      4'h3: c_bus = acc_q | b_bus;
      4'h4: c_bus = acc_q ^ b_bus;
      4'h5: c_bus = ~acc_q;
      4'h6: begin c_bus = {1'b0, acc_q[DW-1:1]}; cout = acc_q[0]; end
      4'h7: begin c_bus = {acc_q[DW-2:0], 1'b0}; cout = acc_q[DW-1]; end
      4'h8: c_bus = b_bus;
      4'h9: begin
        sum = {1'b0, acc_q} + {1'b0, b_bus} + {{DW{1'b0}}, carry_q};
        c_bus = sum[DW-1:0]; cout = sum[DW];
      end
      4'hA: begin
        sum = {1'b0, acc_q} - {1'b0, b_bus} - {{DW{1'b0}}, carry_q};
        c_bus = sum[DW-1:0]; cout = sum[DW];
      end
      4'hB: begin c_bus = {carry_q, acc_q[DW-1:1]}; cout = acc_q[0]; end
      4'hC: begin c_bus = {acc_q[DW-2:0], carry_q}; cout = acc_q[DW-1]; end
      default: c_bus = acc_q;
    endcase
  end

  // External address source select; SP+1 is the read address for a pop
  always_comb begin
    addx_bus = d_bus;
    case (addx_mux)
      2'd1:    addx_bus = pc_q;
      2'd2:    addx_bus = sp_q;
      2'd3:    addx_bus = sp_q + AW'(1);
      default: addx_bus = d_bus;
    endcase
  end

  // Next-state for latches, register file, PC, SP and flags
  always_comb begin
    acc_d   = w_acc  ? acc_q  : c_bus;
    opl_d   = w_opl  ? opl_q  : data_in;
    oplo_d  = w_oplo ? oplo_q : data_in;
    ophi_d  = w_ophi ? ophi_q : data_in[HW-1:0];
    reg_p_d = reg_p_q;  // no load strobe reaches the port register; it holds its reset value
    regs_d  = regs_q;
    if (!w_reg) regs_d[reg_sel] = c_bus;

    pc_d = pc_q;
    case (pc_op_e'(pc_op))
      PC_INC:  pc_d = pc_q + AW'(1);
      PC_LOAD: pc_d = d_bus;
      default: pc_d = pc_q;
    endcase

    sp_d     = sp_q;
    sp_fault = 1'b0;
    case (sp_op_e'(sp_op))
      SP_PUSH: if (sp_q == '0) sp_fault = 1'b1; else sp_d = sp_q - AW'(1);
      SP_POP:  if (sp_q == '1) sp_fault = 1'b1; else sp_d = sp_q + AW'(1);
      default: sp_d = sp_q;
    endcase

    {carry_d, pos_d, zero_d, serr_d} = {carry_q, pos_q, zero_q, serr_q};
    if (!w_flag) begin
      if (flag_mux) begin
        zero_d  = (c_bus == '0);
        pos_d   = ~c_bus[DW-1];
        carry_d = cout;
      end else begin
        {carry_d, pos_d, zero_d, serr_d} = c_bus[DW-1:DW-4];
      end
    end
    // a stack fault wins over a flag load clearing serr in the same cycle
    if (sp_fault) serr_d = 1'b1;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      acc_q   <= '0;
      reg_p_q <= '0;
      opl_q   <= '0;
      oplo_q  <= '0;
      ophi_q  <= '0;
      pc_q    <= '0;
      sp_q    <= '1;
      {carry_q, pos_q, zero_q, serr_q} <= 4'b0000;
      // NOTE: the register file is small and architecturally reset to zero, so it is built from flops, not RAM.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      acc_q   <= acc_d;
      reg_p_q <= reg_p_d;
      opl_q   <= opl_d;
      oplo_q  <= oplo_d;
      ophi_q  <= ophi_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      {carry_q, pos_q, zero_q, serr_q} <= {carry_d, pos_d, zero_d, serr_d};
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_popcorn_dp.sv
// Self-checking bench for popcorn_dp: directed scenarios plus randomized
// cycles against an arithmetic reference model of the datapath.
module tb_popcorn_dp;

  localparam int DW   = 8;
  localparam int AW   = 12;
  localparam int NREG = 4;
  localparam int RSW  = 2;
  localparam int DMOD = 1 << DW;
  localparam int AMOD = 1 << AW;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           w_acc, w_reg, w_flag, w_opl, w_oplo, w_ophi;
  logic [RSW-1:0] reg_sel;
  logic [3:0]     alu_func;
  logic [2:0]     bbus_mux;
  logic           flag_mux;
  logic [1:0]     pc_op, sp_op, addx_mux;
  logic           data_bus_wr;
  logic [DW-1:0]  data_in, data_out, port_in, port_out, c_bus, b_bus;
  logic [DW-1:0]  reg_acc, reg_p, reg_opl;
  logic           data_oe, port_oe;
  logic [AW-1:0]  addx_bus;
  logic [3:0]     reg_flag;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_acc, m_pc, m_sp, m_opl, m_oplo, m_ophi;
  int m_c, m_p, m_z, m_s;
  int m_reg [NREG];
  // model combinational expectations
  int e_b, e_c, e_co, e_addx;

  popcorn_dp #(.DW(DW), .AW(AW), .NREG(NREG), .RSW(RSW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .w_acc(w_acc), .w_reg(w_reg), .w_flag(w_flag), .w_opl(w_opl), .w_oplo(w_oplo), .w_ophi(w_ophi),
    .reg_sel(reg_sel), .alu_func(alu_func), .bbus_mux(bbus_mux), .flag_mux(flag_mux),
    .pc_op(pc_op), .sp_op(sp_op), .addx_mux(addx_mux), .data_bus_wr(data_bus_wr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .addx_bus(addx_bus),
    .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
    .c_bus(c_bus), .b_bus(b_bus), .reg_acc(reg_acc), .reg_p(reg_p), .reg_opl(reg_opl),
    .reg_flag(reg_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_acc = 0; m_pc = 0; m_sp = AMOD - 1; m_opl = 0; m_oplo = 0; m_ophi = 0;
    m_c = 0; m_p = 0; m_z = 0; m_s = 0;
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;
  endtask

  task automatic set_idle();
    w_acc = 1; w_reg = 1; w_flag = 1; w_opl = 1; w_oplo = 1; w_ophi = 1;
    reg_sel = 0; alu_func = 0; bbus_mux = 0; flag_mux = 1;
    pc_op = 0; sp_op = 0; addx_mux = 0; data_bus_wr = 1; data_in = 0; port_in = 0;
  endtask

  // expected b_bus, c_bus, carry-out and address from the current inputs
  task automatic model_comb();
    int a, s, cin;
    a = m_acc; cin = m_c;
    case (int'(bbus_mux))
      1: e_b = m_reg[reg_sel];
      2: e_b = m_pc % DMOD;
      3: e_b = (m_c * 8 + m_p * 4 + m_z * 2 + m_s) * (DMOD / 16) + m_pc / DMOD;
      4: e_b = port_in;
      5: e_b = m_opl;
      default: e_b = m_oplo;
    endcase
    e_co = 0;
    case (int'(alu_func))
      0:  begin s = a + e_b;       e_c = s % DMOD; e_co = (s >= DMOD); end
      1:  begin e_c = (a - e_b + DMOD) % DMOD; e_co = (a < e_b); end
      2:  e_c = a & e_b;
      3:  e_c = a | e_b;
      4:  e_c = a ^ e_b;
      5:  e_c = DMOD - 1 - a;
      6:  begin e_c = a / 2; e_co = a % 2; end
      7:  begin e_c = (a * 2) % DMOD; e_co = a / (DMOD / 2); end
      8:  e_c = e_b;
      9:  begin s = a + e_b + cin; e_c = s % DMOD; e_co = (s >= DMOD); end
      10: begin e_c = (a - e_b - cin + 2 * DMOD) % DMOD; e_co = (a < e_b + cin); end
      11: begin e_c = cin * (DMOD / 2) + a / 2; e_co = a % 2; end
      12: begin e_c = (a * 2) % DMOD + cin; e_co = a / (DMOD / 2); end
      default: e_c = a;
    endcase
    case (int'(addx_mux))
      1: e_addx = m_pc;
      2: e_addx = m_sp;
      3: e_addx = (m_sp + 1) % AMOD;
      default: e_addx = m_ophi * DMOD + m_oplo;
    endcase
  endtask

  // advance one clock and apply the model's view of what the edge does
  task automatic step();
    int n_acc, n_pc, n_sp, n_opl, n_oplo, n_ophi, n_c, n_p, n_z, n_s, fault;
    model_comb();
    n_acc = w_acc ? m_acc : e_c;
    n_opl = w_opl ? m_opl : data_in;
    n_oplo = w_oplo ? m_oplo : data_in;
    n_ophi = w_ophi ? m_ophi : data_in % (AMOD / DMOD);
    n_pc = m_pc;
    if (pc_op == 1) n_pc = (m_pc + 1) % AMOD;
    if (pc_op == 2) n_pc = m_ophi * DMOD + m_oplo;
    n_sp = m_sp; fault = 0;
    if (sp_op == 1) begin if (m_sp == 0) fault = 1; else n_sp = m_sp - 1; end
    if (sp_op == 2) begin if (m_sp == AMOD - 1) fault = 1; else n_sp = m_sp + 1; end
    n_c = m_c; n_p = m_p; n_z = m_z; n_s = m_s;
    if (!w_flag) begin
      if (flag_mux) begin
        n_z = (e_c == 0); n_p = (e_c < DMOD / 2); n_c = e_co;
      end else begin
        n_c = (e_c >> (DW - 1)) & 1; n_p = (e_c >> (DW - 2)) & 1;
        n_z = (e_c >> (DW - 3)) & 1; n_s = (e_c >> (DW - 4)) & 1;
      end
    end
    if (fault) n_s = 1;
    if (!w_reg) m_reg[reg_sel] = e_c;
    @(posedge sys_clk);
    #1;
    m_acc = n_acc; m_opl = n_opl; m_oplo = n_oplo; m_ophi = n_ophi;
    m_pc = n_pc; m_sp = n_sp; m_c = n_c; m_p = n_p; m_z = n_z; m_s = n_s;
  endtask

  task automatic drive_opl(input int v);
    set_idle(); w_opl = 0; data_in = DW'(v); step();
  endtask

  task automatic acc_from_opl();
    set_idle(); alu_func = 4'h8; bbus_mux = 3'd5; w_acc = 0; step();
  endtask

  task automatic test_reset();
    set_idle();
    sys_rst = 0;
    model_reset();
    #12;
    n_tests++; if (reg_acc !== 8'h00 || reg_flag !== 4'h0 || reg_opl !== 8'h00) begin
      n_fail++; $display("FAIL reset_regs: acc=%h flag=%h opl=%h required 00/0/00", reg_acc, reg_flag, reg_opl); end
    n_tests++; if (addx_bus !== 12'h000 || port_oe !== 1'b1) begin
      n_fail++; $display("FAIL reset_addx: addx=%h port_oe=%b required 000/1", addx_bus, port_oe); end
    addx_mux = 2'd2; #1;
    n_tests++; if (addx_bus !== 12'hFFF) begin
      n_fail++; $display("FAIL reset_sp: got %h required FFF", addx_bus); end
    addx_mux = 2'd1; #1;
    n_tests++; if (addx_bus !== 12'h000) begin
      n_fail++; $display("FAIL reset_pc: got %h required 000", addx_bus); end
    @(negedge sys_clk);
    sys_rst = 1;
    set_idle();
    step();
  endtask

  task automatic test_alu_flags();
    drive_opl(8'hFF); acc_from_opl(); drive_opl(8'h01);
    set_idle(); alu_func = 4'h0; bbus_mux = 3'd5; w_flag = 0; flag_mux = 1;
    #1;
    n_tests++; if (c_bus !== 8'h00) begin
      n_fail++; $display("FAIL add_wrap: c_bus=%h required 00", c_bus); end
    step();
    n_tests++; if (reg_flag !== 4'hE) begin
      n_fail++; $display("FAIL add_flags: flag=%h required E", reg_flag); end
    drive_opl(8'h10); acc_from_opl(); drive_opl(8'h20);
    set_idle(); alu_func = 4'h9; bbus_mux = 3'd5;
    #1;
    n_tests++; if (c_bus !== 8'h31) begin
      n_fail++; $display("FAIL adc: c_bus=%h required 31", c_bus); end
    step();
  endtask

  task automatic test_regfile();
    drive_opl(8'hA5);
    set_idle(); alu_func = 4'h8; bbus_mux = 3'd5; reg_sel = 2'd3; w_reg = 0; step();
    set_idle(); bbus_mux = 3'd1; reg_sel = 2'd3; #1;
    n_tests++; if (b_bus !== 8'hA5) begin
      n_fail++; $display("FAIL reg3_read: b_bus=%h required A5", b_bus); end
    for (int i = 0; i < 3; i++) begin
      reg_sel = RSW'(i); #1;
      n_tests++; if (b_bus !== 8'h00) begin
        n_fail++; $display("FAIL reg%0d_untouched: b_bus=%h required 00", i, b_bus); end
    end
    // read-during-write: old value on b_bus, new value after the edge
    set_idle(); bbus_mux = 3'd1; reg_sel = 2'd3; alu_func = 4'h4; w_reg = 0; #1;
    model_comb();
    n_tests++; if (b_bus !== 8'hA5 || c_bus !== DW'(e_c)) begin
      n_fail++; $display("FAIL rdw_old: b=%h c=%h required A5/%h", b_bus, c_bus, e_c); end
    step();
    set_idle(); bbus_mux = 3'd1; reg_sel = 2'd3; #1;
    n_tests++; if (b_bus !== DW'(m_reg[3])) begin
      n_fail++; $display("FAIL rdw_new: b=%h required %h", b_bus, m_reg[3]); end
  endtask

  task automatic test_pc();
    set_idle(); w_oplo = 0; data_in = 8'h34; step();
    set_idle(); w_ophi = 0; data_in = 8'h0F; step();
    set_idle(); pc_op = 2'd2; step();
    set_idle(); addx_mux = 2'd1; #1;
    n_tests++; if (addx_bus !== 12'hF34) begin
      n_fail++; $display("FAIL pc_load: pc=%h required F34", addx_bus); end
    set_idle(); pc_op = 2'd1;
    repeat (204) step();
    set_idle(); addx_mux = 2'd1; #1;
    n_tests++; if (addx_bus !== 12'h000) begin
      n_fail++; $display("FAIL pc_wrap: pc=%h required 000", addx_bus); end
  endtask

  task automatic test_sp();
    int pushes;
    pushes = m_sp;
    set_idle(); sp_op = 2'd1;
    repeat (pushes) step();
    set_idle(); addx_mux = 2'd2; #1;
    n_tests++; if (addx_bus !== 12'h000) begin
      n_fail++; $display("FAIL sp_bottom: sp=%h required 000", addx_bus); end
    drive_opl(8'hE0);
    set_idle(); sp_op = 2'd1; alu_func = 4'h8; bbus_mux = 3'd5; w_flag = 0; flag_mux = 0; step();
    set_idle(); addx_mux = 2'd2; #1;
    n_tests++; if (addx_bus !== 12'h000 || reg_flag !== 4'hF) begin
      n_fail++; $display("FAIL sp_underflow: sp=%h flag=%h required 000/F", addx_bus, reg_flag); end
    addx_mux = 2'd3; #1;
    n_tests++; if (addx_bus !== 12'h001) begin
      n_fail++; $display("FAIL sp_plus1: got %h required 001", addx_bus); end
  endtask

  task automatic test_rcr_port();
    drive_opl(8'h80);
    set_idle(); alu_func = 4'h8; bbus_mux = 3'd5; w_acc = 0; w_flag = 0; flag_mux = 0; step();
    set_idle(); alu_func = 4'hB; w_flag = 0; flag_mux = 1; #1;
    n_tests++; if (c_bus !== 8'hC0) begin
      n_fail++; $display("FAIL rcr: c_bus=%h required C0", c_bus); end
    step();
    n_tests++; if (reg_flag !== 4'h0) begin
      n_fail++; $display("FAIL rcr_flags: flag=%h required 0", reg_flag); end
    set_idle(); bbus_mux = 3'd4; port_in = DW'($urandom); data_bus_wr = 0; #1;
    n_tests++; if (port_oe !== 1'b0 || b_bus !== port_in || data_oe !== 1'b1) begin
      n_fail++; $display("FAIL port_read: oe=%b b=%h doe=%b required 0/%h/1", port_oe, b_bus, data_oe, port_in); end
    bbus_mux = 3'd2; #1;
    n_tests++; if (port_oe !== 1'b1) begin
      n_fail++; $display("FAIL port_oe_release: got %b required 1", port_oe); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      w_acc = 1'($urandom); w_reg = 1'($urandom); w_flag = 1'($urandom);
      w_opl = 1'($urandom); w_oplo = 1'($urandom); w_ophi = 1'($urandom);
      reg_sel = RSW'($urandom); alu_func = 4'($urandom); bbus_mux = 3'($urandom);
      flag_mux = 1'($urandom); pc_op = 2'($urandom); sp_op = 2'($urandom);
      addx_mux = 2'($urandom); data_bus_wr = 1'($urandom);
      data_in = DW'($urandom); port_in = DW'($urandom);
      #1;
      model_comb();
      n_tests++; if (b_bus !== DW'(e_b) || c_bus !== DW'(e_c) || data_out !== DW'(e_c)) begin
        n_fail++; $display("FAIL rnd_alu[%0d]: func=%h mux=%0d b=%h c=%h out=%h required b=%h c=%h",
                           it, alu_func, bbus_mux, b_bus, c_bus, data_out, e_b, e_c); end
      n_tests++; if (addx_bus !== AW'(e_addx) || port_oe !== (bbus_mux != 3'd4) || data_oe !== ~data_bus_wr) begin
        n_fail++; $display("FAIL rnd_addx[%0d]: addx=%h poe=%b doe=%b required %h", it, addx_bus, port_oe, data_oe, e_addx); end
      step();
      n_tests++; if (reg_acc !== DW'(m_acc) || reg_opl !== DW'(m_opl) || port_out !== 8'h00 || reg_p !== 8'h00) begin
        n_fail++; $display("FAIL rnd_state[%0d]: acc=%h opl=%h p=%h required %h/%h/00", it, reg_acc, reg_opl, reg_p, m_acc, m_opl); end
      n_tests++; if (reg_flag !== {1'(m_c), 1'(m_p), 1'(m_z), 1'(m_s)}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: flag=%h required %0d%0d%0d%0d", it, reg_flag, m_c, m_p, m_z, m_s); end
    end
  endtask

  task automatic test_async_reset();
    set_idle(); w_acc = 0; alu_func = 4'h5; sp_op = 2'd1; step();
    set_idle(); addx_mux = 2'd2;
    @(posedge sys_clk); #3;
    sys_rst = 0; #1;
    model_reset();
    n_tests++; if (reg_acc !== 8'h00 || reg_flag !== 4'h0 || addx_bus !== 12'hFFF) begin
      n_fail++; $display("FAIL async_reset: acc=%h flag=%h sp=%h required 00/0/FFF", reg_acc, reg_flag, addx_bus); end
    @(negedge sys_clk);
    sys_rst = 1;
  endtask

  initial begin
    test_reset();
    test_alu_flags();
    test_regfile();
    test_pc();
    test_sp();
    test_rcr_port();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
